// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// State numbering is visible on the debug port, so keep it stable.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_ORIEX  = 4'd10,
        S_ORIWB  = 4'd11,
        S_JRSAL  = 4'd12,
        S_BALN   = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_RS     = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [5:0] OPC_R     = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_JRSAL = 6'b010001;
    localparam logic [5:0] OPC_BALN  = 6'b011001;

    // States that hold a memory access open until mem_ready
    function automatic logic is_mem_wait(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive stalled cycles of a memory access and flags
// the cycle in which the stall budget runs out.
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);

    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [W-1:0] count;

    // The current cycle is the LIMIT-th stalled one; ready on it still wins
    always_comb begin
        timeout = 1'b0;
        if (LIMIT != 0 && waiting && !mem_ready && count == LAST)
            timeout = 1'b1;
    end

    // Count stalled cycles; any completion or state change clears
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (LIMIT != 0 && waiting && !mem_ready && !timeout)
            count <= count + 1'b1;
        else
            count <= '0;
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS-subset datapath.
// Moore outputs per state; fetch strobes and memory exits gated by mem_ready.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int unsigned        OP_W        = 6,
    parameter logic [OP_W-1:0]    OP_R        = OPC_R,
    parameter logic [OP_W-1:0]    OP_LW       = OPC_LW,
    parameter logic [OP_W-1:0]    OP_SW       = OPC_SW,
    parameter logic [OP_W-1:0]    OP_BEQ      = OPC_BEQ,
    parameter logic [OP_W-1:0]    OP_ORI      = OPC_ORI,
    parameter logic [OP_W-1:0]    OP_JRSAL    = OPC_JRSAL,
    parameter logic [OP_W-1:0]    OP_BALN     = OPC_BALN,
    parameter int unsigned        MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            irwrite,
    output logic            pcwrite,
    output logic            pcwritecond,
    output logic            branch_sel,
    output logic            iord,
    output logic            memread,
    output logic            memwrite,
    output logic [1:0]      memtoreg,
    output logic [1:0]      regdst,
    output logic            regwrite,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic            ext_zero,
    output logic [1:0]      aluop,
    output logic [1:0]      pcsource,
    output logic            illegal,
    output logic            mem_fault,
    output logic [3:0]      state
);

    state_t cur;
    state_t nxt;
    logic   is_store;
    logic   timeout;
    logic   bad_op;

    assign state = cur;

    mc_wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .waiting  (is_mem_wait(cur)),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    // Opcode outside the supported set
    always_comb begin
        bad_op = !(opcode == OP_R   || opcode == OP_LW    ||
                   opcode == OP_SW  || opcode == OP_BEQ   ||
                   opcode == OP_ORI || opcode == OP_JRSAL ||
                   opcode == OP_BALN);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cur <= S_IDLE;
        else
            cur <= nxt;
    end

    // Sticky trap flags and the load/store choice captured at decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal   <= 1'b0;
            mem_fault <= 1'b0;
            is_store  <= 1'b0;
        end else begin
            if (cur == S_DECODE) begin
                is_store <= (opcode == OP_SW);
                if (bad_op)
                    illegal <= 1'b1;
            end
            if (timeout)
                mem_fault <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        nxt = cur;
        unique case (cur)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)
                    nxt = S_DECODE;
                else if (timeout)
                    nxt = S_TRAP;
            end
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW)
                    nxt = S_MEMADR;
                else if (opcode == OP_R)
                    nxt = S_EXEC;
                else if (opcode == OP_BEQ)
                    nxt = S_BEQ;
                else if (opcode == OP_ORI)
                    nxt = S_ORIEX;
                else if (opcode == OP_JRSAL)
                    nxt = S_JRSAL;
                else if (opcode == OP_BALN)
                    nxt = S_BALN;
                else
                    nxt = S_TRAP;
            end
            S_MEMADR: nxt = is_store ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)
                    nxt = S_MEMWB;
                else if (timeout)
                    nxt = S_TRAP;
            end
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR: begin
                if (mem_ready)
                    nxt = S_FETCH;
                else if (timeout)
                    nxt = S_TRAP;
            end
            S_EXEC:   nxt = S_RWB;
            S_RWB:    nxt = S_FETCH;
            S_BEQ:    nxt = S_FETCH;
            S_ORIEX:  nxt = S_ORIWB;
            S_ORIWB:  nxt = S_FETCH;
            S_JRSAL:  nxt = S_FETCH;
            S_BALN:   nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_TRAP;
        endcase
    end

    // Datapath strobes and selects for the current state
    always_comb begin
        irwrite     = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        branch_sel  = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = M2R_ALUOUT;
        regdst      = RD_RT;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_RT;
        ext_zero    = 1'b0;
        aluop       = ALU_ADD;
        pcsource    = PCS_ALU;
        unique case (cur)
            S_FETCH: begin
                memread  = 1'b1;
                alusrcb  = SRCB_FOUR;
                irwrite  = mem_ready;
                pcwrite  = mem_ready;
            end
            S_DECODE: begin
                alusrcb  = SRCB_IMMSH;
            end
            S_MEMADR: begin
                alusrca  = 1'b1;
                alusrcb  = SRCB_IMM;
            end
            S_MEMRD: begin
                memread  = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = M2R_MDR;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca  = 1'b1;
                aluop    = ALU_FUNCT;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = RD_RD;
            end
            S_BEQ: begin
                alusrca     = 1'b1;
                aluop       = ALU_SUB;
                pcwritecond = 1'b1;
                pcsource    = PCS_ALUOUT;
            end
            S_ORIEX: begin
                alusrca  = 1'b1;
                alusrcb  = SRCB_IMM;
                ext_zero = 1'b1;
                aluop    = ALU_OR;
            end
            S_ORIWB: begin
                regwrite = 1'b1;
            end
            S_JRSAL: begin
                pcwrite  = 1'b1;
                pcsource = PCS_RS;
                regwrite = 1'b1;
                regdst   = RD_RA;
                memtoreg = M2R_PC;
            end
            S_BALN: begin
                alusrca     = 1'b1;
                aluop       = ALU_SUB;
                pcwritecond = 1'b1;
                branch_sel  = 1'b1;
                pcsource    = PCS_ALUOUT;
                regwrite    = 1'b1;
                regdst      = RD_RA;
                memtoreg    = M2R_PC;
            end
            default: ;
        endcase
    end

endmodule
